// File: rtl/quadencoderz_homing_ctrl.sv
// Index (Z) homing sequencer for one quadencoderz: arms indexenable, waits for the index
// rise, captures the pre-zero position. Optional drift output under QUADZ_HOMING_DRIFT_EN.
module quadencoderz_homing_ctrl #(
    parameter int POS_W     = 32,
    parameter int TIMEOUT_W = 32,
    parameter int TIMEOUT   = 48000000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [POS_W-1:0] position,
    input  logic             indexout,
    output logic             indexenable,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [POS_W-1:0] index_pos,
    output logic [CNT_W-1:0] index_count
`ifdef QUADZ_HOMING_DRIFT_EN
    ,
    output logic [POS_W-1:0] index_drift
`endif
);

    // state   | meaning
    // IDLE    | disarmed, accepts start
    // ARM     | one cycle, indexenable raised
    // WAIT    | armed, timing out, watching for an index rise
    // CAPTURE | one cycle, done pulse and captured position visible
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] timer, timer_nxt;
    logic [POS_W-1:0]     pos_d;
    logic                 idx_d;
    logic                 idx_rise;
    logic                 timeout_hit;
    logic                 capture;
    logic                 terr_nxt;

    assign idx_rise    = indexout & ~idx_d;
    assign timeout_hit = (TIMEOUT != 0) && (timer == TIMEOUT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        terr_nxt  = timeout_err;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = ARM;
                    timer_nxt = '0;
                    terr_nxt  = 1'b0;
                end
            end
            ARM:     state_nxt = WAIT;
            WAIT: begin
                timer_nxt = timer + TIMEOUT_W'(1);
                // an index rise on the terminal cycle still counts as a successful home
                if (idx_rise) begin
                    state_nxt = CAPTURE;
                    capture   = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                    terr_nxt  = 1'b1;
                end
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            capture   = 1'b0;
            terr_nxt  = timeout_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            pos_d       <= '0;
            idx_d       <= 1'b0;
            indexenable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            index_pos   <= '0;
            index_count <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            pos_d       <= position;
            idx_d       <= indexout;
            indexenable <= (state_nxt == ARM) || (state_nxt == WAIT);
            busy        <= (state_nxt == ARM) || (state_nxt == WAIT);
            done        <= capture;
            timeout_err <= terr_nxt;
            if (capture) begin
                index_pos   <= pos_d;
                index_count <= index_count + CNT_W'(1);
            end
        end
    end

`ifdef QUADZ_HOMING_DRIFT_EN
    // drift is relative to the previous capture, so the first capture has nothing to compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_drift <= '0;
        end else if (capture && (index_count != '0)) begin
            index_drift <= pos_d - index_pos;
        end
    end
`endif

endmodule

// File: tb/tb_quadencoderz_homing_ctrl.sv
// Self-checking bench for quadencoderz_homing_ctrl: directed homing sequences checked
// against a cycle-count model of the homing rules plus literal expectations.
module tb_quadencoderz_homing_ctrl;

    localparam int POS_W   = 32;
    localparam int TMO     = 100;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [POS_W-1:0] position;
    logic             indexout;
    logic             indexenable;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [POS_W-1:0] index_pos;
    logic [CNT_W-1:0] index_count;
`ifdef QUADZ_HOMING_DRIFT_EN
    logic [POS_W-1:0] index_drift;
`endif

    quadencoderz_homing_ctrl #(
        .POS_W(POS_W), .TIMEOUT_W(32), .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .position(position), .indexout(indexout),
        .indexenable(indexenable), .busy(busy), .done(done),
        .timeout_err(timeout_err), .index_pos(index_pos), .index_count(index_count)
`ifdef QUADZ_HOMING_DRIFT_EN
        , .index_drift(index_drift)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: age = -1 when not homing, 0 on the arm cycle, n>=1 on the n-th waiting cycle.
    int               age;
    bit               m_done, m_terr, m_prev_idx, rise;
    logic [POS_W-1:0] m_pos, m_prev_pos, m_drift;
    int               m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age = -1; m_done = 0; m_terr = 0; m_pos = '0; m_cnt = 0;
            m_drift = '0; m_prev_idx = 0; m_prev_pos = '0;
        end else begin
            rise = indexout && !m_prev_idx;
            if (abort) begin
                age = -1; m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (age < 0) begin
                if (start) begin age = 0; m_terr = 0; end
            end else if (age == 0) begin
                age = 1;
            end else if (rise) begin
                if (m_cnt != 0) m_drift = m_prev_pos - m_pos;
                m_pos  = m_prev_pos;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_done = 1;
                age    = -1;
            end else if (age == TMO) begin
                m_terr = 1; age = -1;
            end else begin
                age++;
            end
            m_prev_idx = indexout;
            m_prev_pos = position;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("indexenable", indexenable, age >= 0);
            chk("busy", busy, age >= 0);
            chk("done", done, m_done);
            chk("timeout_err", timeout_err, m_terr);
            chk("index_pos", index_pos, m_pos);
            chk("index_count", index_count, m_cnt[CNT_W-1:0]);
`ifdef QUADZ_HOMING_DRIFT_EN
            chk("index_drift", index_drift, m_drift);
`endif
        end
    end

    task automatic home_once(input logic [POS_W-1:0] p);
        @(negedge clk); position = p; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); indexout = 1'b1; position = '0;
        @(negedge clk); indexout = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; position = '0; indexout = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ie", indexenable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_pos", index_pos, 32'd0);
        chk("rst_cnt", index_count, 4'd0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ie", indexenable, 1'b0);

        // basic home at position 20
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) chk("arm_ie", indexenable, 1'b1);
            position = k;
            start    = (k == 5);
        end
        @(negedge clk); indexout = 1'b1; position = '0;
        @(negedge clk);
        chk("home_done", done, 1'b1);
        chk("home_pos", index_pos, 32'd20);
        chk("home_cnt", index_count, 4'd1);
        chk("home_ie", indexenable, 1'b0);
        indexout = 1'b0;
        repeat (3) @(negedge clk);

        // timeout: error exactly TMO cycles after the ARM->WAIT edge
        position = 32'd77;
        pulse_start();
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_early_terr", timeout_err, 1'b0);
        chk("tmo_early_busy", busy, 1'b1);
        @(negedge clk);
        chk("tmo_terr", timeout_err, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        pulse_start();
        chk("restart_terr", timeout_err, 1'b0);
        chk("restart_ie", indexenable, 1'b1);

        // abort mid-wait
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_ie", indexenable, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (3) @(negedge clk);

        // index level already high when armed is ignored until a fresh rise
        indexout = 1'b1; position = 32'd33;
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("hold_done", done, 1'b0);
        chk("hold_busy", busy, 1'b1);
        indexout = 1'b0;
        @(negedge clk); indexout = 1'b1; position = '0;
        @(negedge clk);
        chk("hold_rise_done", done, 1'b1);
        chk("hold_rise_pos", index_pos, 32'd33);
        indexout = 1'b0;
        repeat (2) @(negedge clk);

        // start and abort together
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("sa_ie", indexenable, 1'b0);
        chk("sa_busy", busy, 1'b0);
        repeat (2) @(negedge clk);

        // index rise on the timeout terminal cycle
        position = 32'd55;
        pulse_start();
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        indexout = 1'b1; position = '0;
        @(negedge clk);
        chk("term_done", done, 1'b1);
        chk("term_terr", timeout_err, 1'b0);
        chk("term_pos", index_pos, 32'd55);
        indexout = 1'b0;
        repeat (2) @(negedge clk);

        // index_count wrap
        guard = 0;
        while (m_cnt != (1 << CNT_W) - 1 && guard < 40) begin
            home_once(32'(guard * 3 + 1));
            guard++;
        end
        chk("wrap_pre", index_count, 4'hF);
        home_once(32'd9);
        chk("wrap_cnt", index_count, 4'h0);
        chk("wrap_pos", index_pos, 32'd9);

`ifdef QUADZ_HOMING_DRIFT_EN
        home_once(32'd20);
        home_once(32'd24);
        chk("drift_pos", index_drift, 32'd4);
        home_once(32'd17);
        chk("drift_neg", index_drift, 32'hFFFF_FFF9);
`endif

        // async reset mid-wait drops indexenable without a clock
        pulse_start();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_ie", indexenable, 1'b0);
        chk("async_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
